// File: rtl/yolo_to_ddr_axi_wr.sv
// YOLO result write-back: packs four 64-bit stream beats into one 256-bit word and writes it to DDR as single-beat AXI bursts.
// Optional feature: define YOLO_WR_TLAST_FLUSH_EN to let an early tlast flush a partial word and end the frame.
module yolo_to_ddr_axi_wr #(
    parameter logic [31:0] CMD_CODE = 32'h0000_0040,
    parameter int          ADDR_W   = 28
) (
    input  logic         axi_clk,
    input  logic         axi_rst,
    input  logic [31:0]  slave_lite_reg5,
    input  logic [31:0]  data_wr_len,
    input  logic [31:0]  data_wr_awaddr,
    input  logic [63:0]  s_axis_s2mm_tdata,
    input  logic [7:0]   s_axis_s2mm_tkeep,
    input  logic         s_axis_s2mm_tvalid,
    output logic         s_axis_s2mm_tready,
    input  logic         s_axis_s2mm_tlast,
    output logic [31:0]  axi_awaddr,
    output logic [3:0]   axi_awuser_id,
    output logic [3:0]   axi_awlen,
    output logic         axi_awvalid,
    input  logic         axi_awready,
    output logic [255:0] axi_wdata,
    output logic [31:0]  axi_wstrb,
    output logic         axi_wlast,
    input  logic         axi_wready,
    output logic         wr_done,
    output logic         tlast_err,
    output logic [2:0]   dbg_state_o
);

    // Handshakes: a stream beat transfers on a clock edge where tvalid and tready are both high;
    // an AXI address/data transfer happens on the edge where awvalid&awready (wlast&wready) are high.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PACK = 3'd1,
        S_AW   = 3'd2,
        S_W    = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [31:0]         len_q, len_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [31:0]         byte_cnt_q, byte_cnt_d;
    logic [1:0]          lane_q, lane_d;
    logic [255:0]        pack_q, pack_d;
    logic [31:0]         strb_q, strb_d;
    logic                tlast_err_q, tlast_err_d;
    logic                flush_q, flush_d;

    logic [ADDR_W-1:0]   addr_sum;
    logic                last_beat;
    logic                word_is_last;
    logic                unused_inputs;

    assign unused_inputs = ^{s_axis_s2mm_tkeep, data_wr_awaddr[31:ADDR_W]};

    assign addr_sum     = base_q + byte_cnt_q[ADDR_W-1:0];
    // 33-bit compares keep a length near 2^32 from wrapping the end-of-transfer test.
    assign word_is_last = ({1'b0, byte_cnt_q} + 33'd32) >= {1'b0, len_q};
    assign last_beat    = (lane_q == 2'd3) && word_is_last;

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            base_q      <= '0;
            byte_cnt_q  <= '0;
            lane_q      <= '0;
            pack_q      <= '0;
            strb_q      <= '0;
            tlast_err_q <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            base_q      <= base_d;
            byte_cnt_q  <= byte_cnt_d;
            lane_q      <= lane_d;
            pack_q      <= pack_d;
            strb_q      <= strb_d;
            tlast_err_q <= tlast_err_d;
            flush_q     <= flush_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        base_d      = base_q;
        byte_cnt_d  = byte_cnt_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        strb_d      = strb_q;
        tlast_err_d = tlast_err_q;
        flush_d     = flush_q;

        case (state_q)
            S_IDLE: begin
                if (slave_lite_reg5 == CMD_CODE) begin
                    len_d       = data_wr_len;
                    base_d      = data_wr_awaddr[ADDR_W-1:0];
                    byte_cnt_d  = '0;
                    lane_d      = '0;
                    tlast_err_d = 1'b0;
                    flush_d     = 1'b0;
                    state_d     = (data_wr_len == 32'd0) ? S_DONE : S_PACK;
                end
            end
            S_PACK: begin
                if (s_axis_s2mm_tvalid) begin
                    // Lane 0 starts a fresh word, so stale upper lanes never leak into a partial flush.
                    case (lane_q)
                        2'd0:    pack_d = {192'd0, s_axis_s2mm_tdata};
                        2'd1:    pack_d[127:64]  = s_axis_s2mm_tdata;
                        2'd2:    pack_d[191:128] = s_axis_s2mm_tdata;
                        default: pack_d[255:192] = s_axis_s2mm_tdata;
                    endcase
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        strb_d  = 32'hFFFF_FFFF;
                        state_d = S_AW;
                    end
                    if (s_axis_s2mm_tlast && !last_beat) begin
`ifdef YOLO_WR_TLAST_FLUSH_EN
                        flush_d = 1'b1;
                        lane_d  = 2'd0;
                        state_d = S_AW;
                        case (lane_q)
                            2'd0:    strb_d = 32'h0000_00FF;
                            2'd1:    strb_d = 32'h0000_FFFF;
                            2'd2:    strb_d = 32'h00FF_FFFF;
                            default: strb_d = 32'hFFFF_FFFF;
                        endcase
`else
                        tlast_err_d = 1'b1;
`endif
                    end
                end
            end
            S_AW: begin
                if (axi_awready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                if (axi_wready) begin
                    byte_cnt_d = byte_cnt_q + 32'd32;
                    state_d    = (word_is_last || flush_q) ? S_DONE : S_PACK;
                end
            end
            S_DONE: begin
                if (slave_lite_reg5 == 32'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign s_axis_s2mm_tready = (state_q == S_PACK);
    assign axi_awvalid        = (state_q == S_AW);
    assign axi_awaddr         = axi_awvalid ? {{(32-ADDR_W){1'b0}}, addr_sum} : 32'd0;
    assign axi_awuser_id      = 4'h0;
    assign axi_awlen          = 4'h0;
    assign axi_wdata          = pack_q;
    assign axi_wlast          = (state_q == S_W);
    assign axi_wstrb          = axi_wlast ? strb_q : 32'd0;
    assign wr_done            = (state_q == S_DONE);
    assign tlast_err          = tlast_err_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_yolo_to_ddr_axi_wr.sv
// Directed bench for yolo_to_ddr_axi_wr: stream beats in, AXI address/data handshakes out, compared against hand-built words.
module tb_yolo_to_ddr_axi_wr;

    localparam logic [31:0] CMD = 32'h0000_0040;

    logic         clk;
    logic         rst;
    logic [31:0]  reg5;
    logic [31:0]  wr_len;
    logic [31:0]  wr_base;
    logic [63:0]  tdata;
    logic [7:0]   tkeep;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic [31:0]  awaddr;
    logic [3:0]   awuser_id;
    logic [3:0]   awlen;
    logic         awvalid;
    logic         awready;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic         wlast;
    logic         wready;
    logic         done;
    logic         terr;
    logic [2:0]   dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    yolo_to_ddr_axi_wr dut (
        .axi_clk            (clk),
        .axi_rst            (rst),
        .slave_lite_reg5    (reg5),
        .data_wr_len        (wr_len),
        .data_wr_awaddr     (wr_base),
        .s_axis_s2mm_tdata  (tdata),
        .s_axis_s2mm_tkeep  (tkeep),
        .s_axis_s2mm_tvalid (tvalid),
        .s_axis_s2mm_tready (tready),
        .s_axis_s2mm_tlast  (tlast),
        .axi_awaddr         (awaddr),
        .axi_awuser_id      (awuser_id),
        .axi_awlen          (awlen),
        .axi_awvalid        (awvalid),
        .axi_awready        (awready),
        .axi_wdata          (wdata),
        .axi_wstrb          (wstrb),
        .axi_wlast          (wlast),
        .axi_wready         (wready),
        .wr_done            (done),
        .tlast_err          (terr),
        .dbg_state_o        (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bv(input int w, input int b);
        return {32'hCAFE_0000 + 32'(w * 16 + b), 32'h1234_0000 + 32'(w * 16 + b)};
    endfunction

    function automatic logic [255:0] word_of(input int w);
        return {bv(w, 3), bv(w, 2), bv(w, 1), bv(w, 0)};
    endfunction

    // Driver tasks
    task automatic arm(input logic [31:0] base, input logic [31:0] len);
        reg5    = CMD;
        wr_base = base;
        wr_len  = len;
        @(posedge clk); #1;
    endtask

    task automatic disarm();
        reg5 = 32'd0;
        @(posedge clk); #1;
        chk("idle_after_disarm", 256'(dbg_state), 256'(3'd0));
        chk("done_low_after_disarm", 256'(done), 256'(1'b0));
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last);
        bit got;
        got    = 1'b0;
        tdata  = d;
        tlast  = last;
        tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tready) begin
                got = 1'b1;
                break;
            end
        end
        chk("beat_accepted", 256'(got), 256'(1'b1));
        if (got) begin
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_word(input int w, input int tlast_beat);
        for (int b = 0; b < 4; b++) begin
            send_beat(bv(w, b), (b == tlast_beat));
        end
    endtask

    task automatic aw_accept(input logic [31:0] exp_addr, input int delay);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (awvalid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("awvalid_seen", 256'(seen), 256'(1'b1));
        chk("awaddr", 256'(awaddr), 256'(exp_addr));
        chk("awlen", 256'(awlen), 256'(4'h0));
        chk("tready_low_in_aw", 256'(tready), 256'(1'b0));
        chk("wlast_low_in_aw", 256'(wlast), 256'(1'b0));
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("awvalid_held", 256'(awvalid), 256'(1'b1));
            chk("tready_low_aw_stall", 256'(tready), 256'(1'b0));
        end
        awready = 1'b1;
        @(posedge clk); #1;
        awready = 1'b0;
        chk("awvalid_drop", 256'(awvalid), 256'(1'b0));
    endtask

    task automatic w_accept(input logic [255:0] exp_data, input logic [31:0] exp_strb, input int delay);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wlast) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wlast_seen", 256'(seen), 256'(1'b1));
        chk("wdata", wdata, exp_data);
        chk("wstrb", 256'(wstrb), 256'(exp_strb));
        chk("no_aw_w_overlap", 256'(awvalid), 256'(1'b0));
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("wlast_held", 256'(wlast), 256'(1'b1));
            chk("wdata_held", wdata, exp_data);
            chk("tready_low_w_stall", 256'(tready), 256'(1'b0));
        end
        wready = 1'b1;
        @(posedge clk); #1;
        wready = 1'b0;
    endtask

    // Directed sequence
    initial begin
        rst     = 1'b1;
        reg5    = 32'd0;
        wr_len  = 32'd0;
        wr_base = 32'd0;
        tdata   = 64'd0;
        tkeep   = 8'hFF;
        tvalid  = 1'b0;
        tlast   = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_state", 256'(dbg_state), 256'(3'd0));
        chk("rst_awvalid", 256'(awvalid), 256'(1'b0));
        chk("rst_tready", 256'(tready), 256'(1'b0));
        chk("rst_wlast", 256'(wlast), 256'(1'b0));
        chk("rst_wstrb", 256'(wstrb), 256'(32'd0));
        chk("rst_wdata", wdata, 256'd0);
        chk("rst_done", 256'(done), 256'(1'b0));
        chk("rst_terr", 256'(terr), 256'(1'b0));
        chk("awuser_id", 256'(awuser_id), 256'(4'h0));

        // Single word, first beat lands in the LSBs
        arm(32'h0000_0100, 32'd32);
        chk("t1_pack", 256'(dbg_state), 256'(3'd1));
        chk("t1_tready", 256'(tready), 256'(1'b1));
        send_beat(64'h1111_1111_1111_1111, 1'b0);
        send_beat(64'h2222_2222_2222_2222, 1'b0);
        send_beat(64'h3333_3333_3333_3333, 1'b0);
        send_beat(64'h4444_4444_4444_4444, 1'b1);
        aw_accept(32'h0000_0100, 0);
        w_accept({64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 32'hFFFF_FFFF, 0);
        chk("t1_done", 256'(done), 256'(1'b1));
        chk("t1_terr", 256'(terr), 256'(1'b0));
        chk("t1_tready_done", 256'(tready), 256'(1'b0));
        disarm();

        // Three words with stalled address and data channels
        arm(32'h0000_2000, 32'd96);
        for (int w = 0; w < 3; w++) begin
            send_word(w, (w == 2) ? 3 : -1);
            aw_accept(32'h0000_2000 + 32'(w * 32), 5);
            w_accept(word_of(w), 32'hFFFF_FFFF, 3);
        end
        chk("t2_done", 256'(done), 256'(1'b1));
        chk("t2_terr", 256'(terr), 256'(1'b0));
        disarm();

        // Zero length goes straight to DONE
        arm(32'h0000_3000, 32'd0);
        chk("t3_done", 256'(done), 256'(1'b1));
        chk("t3_state", 256'(dbg_state), 256'(3'd4));
        chk("t3_awvalid", 256'(awvalid), 256'(1'b0));
        chk("t3_tready", 256'(tready), 256'(1'b0));
        disarm();

        // Address wraps at 2^28
        arm(32'h0FFF_FFE0, 32'd64);
        send_word(4, 3 + 4);
        aw_accept(32'h0FFF_FFE0, 0);
        w_accept(word_of(4), 32'hFFFF_FFFF, 0);
        send_word(5, 3);
        aw_accept(32'h0000_0000, 1);
        w_accept(word_of(5), 32'hFFFF_FFFF, 1);
        chk("t4_done", 256'(done), 256'(1'b1));
        disarm();

        // Early tlast on the second beat
        arm(32'h0000_4000, 32'd32);
        send_beat(bv(6, 0), 1'b0);
        send_beat(bv(6, 1), 1'b1);
`ifdef YOLO_WR_TLAST_FLUSH_EN
        aw_accept(32'h0000_4000, 0);
        w_accept({128'd0, bv(6, 1), bv(6, 0)}, 32'h0000_FFFF, 0);
        chk("t5_terr", 256'(terr), 256'(1'b0));
`else
        chk("t5_terr_set", 256'(terr), 256'(1'b1));
        send_beat(bv(6, 2), 1'b0);
        send_beat(bv(6, 3), 1'b0);
        aw_accept(32'h0000_4000, 0);
        w_accept(word_of(6), 32'hFFFF_FFFF, 0);
        chk("t5_terr_sticky", 256'(terr), 256'(1'b1));
`endif
        chk("t5_done", 256'(done), 256'(1'b1));
        disarm();
        arm(32'h0000_4100, 32'd32);
        chk("t5_terr_cleared_on_arm", 256'(terr), 256'(1'b0));
        send_word(7, 3);
        aw_accept(32'h0000_4100, 0);
        w_accept(word_of(7), 32'hFFFF_FFFF, 0);
        chk("t5b_done", 256'(done), 256'(1'b1));
        disarm();

        // Reset while in W
        arm(32'h0000_5000, 32'd32);
        send_word(8, 3);
        aw_accept(32'h0000_5000, 0);
        chk("t6_in_w", 256'(dbg_state), 256'(3'd3));
        reg5 = 32'd0;
        rst  = 1'b1;
        @(posedge clk); #1;
        rst  = 1'b0;
        chk("t6_state", 256'(dbg_state), 256'(3'd0));
        chk("t6_wlast", 256'(wlast), 256'(1'b0));
        chk("t6_wstrb", 256'(wstrb), 256'(32'd0));
        chk("t6_wdata", wdata, 256'd0);
        chk("t6_awvalid", 256'(awvalid), 256'(1'b0));
        chk("t6_awaddr", 256'(awaddr), 256'(32'd0));
        chk("t6_tready", 256'(tready), 256'(1'b0));
        chk("t6_done", 256'(done), 256'(1'b0));
        arm(32'h0000_6000, 32'd32);
        send_word(9, 3);
        aw_accept(32'h0000_6000, 2);
        w_accept(word_of(9), 32'hFFFF_FFFF, 2);
        chk("t6_rearm_done", 256'(done), 256'(1'b1));
        disarm();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
